// File: rtl/replica_pkg.sv
// replica_pkg: shared constants and types for the replica-exchange datapath.
// Holds the fixed-point format of the exp() evaluator, its term count and its
// controller state encoding.
package replica_pkg;
  localparam int EXP_FRAC  = 15;             // fractional bits of x, y, recip and result
  localparam int EXP_ONE   = 1 << EXP_FRAC;  // 1.0 in Q.15
  localparam int EXP_TERMS = 15;             // Taylor terms, n = 15 .. 1
  localparam int EXP_VAL_W = EXP_FRAC + 2;   // Q1.15 unsigned, wide enough for 1.0

  typedef enum logic {E_IDLE, E_STEP} exp_state_t;
endpackage

// File: rtl/exp_horner_step.sv
// exp_horner_step: one combinational Horner step of the exp() series,
//   t = (x * recip) >>> 15, p = (t * y) >>> 15, y_o = sat(1.0 + p).
// Kept in its own module so the multiplier pair can be pipelined in isolation.
// Ports:
//   x_i     signed X_W  argument, already clamped to [X_MIN, 0]
//   recip_i unsigned Q1.15 value of 1/n
//   y_i     signed Y_W  current accumulator
//   y_o     signed Y_W  next accumulator, saturated to the Y_W range
module exp_horner_step
  import replica_pkg::*;
#(
  parameter int X_W = 24,
  parameter int Y_W = 24
) (
  input  logic signed [X_W-1:0]       x_i,
  input  logic        [EXP_VAL_W-1:0] recip_i,
  input  logic signed [Y_W-1:0]       y_i,
  output logic signed [Y_W-1:0]       y_o
);
  // |x * recip| <= |x| * 2^15, so X_W+15 bits hold the product exactly.
  localparam int TW = X_W + EXP_FRAC;
  localparam int PW = X_W + Y_W;
  localparam int SW = PW - EXP_FRAC + 1;   // p plus one guard bit for the +1.0

  logic signed [TW-1:0] prod_t;
  logic signed [X_W-1:0] t;
  logic signed [PW-1:0] prod_p;
  logic signed [PW-EXP_FRAC-1:0] p;
  logic signed [SW-1:0] sum;
  logic unused_lsb;

  always_comb begin
    prod_t = TW'(x_i) * TW'($signed({1'b0, recip_i}));
    t      = prod_t[TW-1:EXP_FRAC];          // arithmetic shift, floor
    prod_p = PW'(t) * PW'(y_i);
    p      = prod_p[PW-1:EXP_FRAC];
    sum    = SW'(p) + SW'(EXP_ONE);
    // In range when every bit above the Y_W sign bit matches it.
    if (&sum[SW-1:Y_W-1] || ~|sum[SW-1:Y_W-1])
      y_o = sum[Y_W-1:0];
    else if (sum[SW-1])
      y_o = {1'b1, {(Y_W-1){1'b0}}};
    else
      y_o = {1'b0, {(Y_W-1){1'b1}}};
  end

  // Discarded fraction bits of the two truncating shifts.
  assign unused_lsb = ^{prod_t[EXP_FRAC-1:0], prod_p[EXP_FRAC-1:0]};
endmodule

// File: rtl/exp_taylor_unit.sv
// exp_taylor_unit: evaluates exp(x) for x <= 0 with a 15-term Horner Taylor
// series, consuming one 1/n word per exp_run cycle (n = 15 .. 1).
// Ports:
//   clk, reset      clock; synchronous active-low reset
//   exp_init        start/restart pulse, samples exp_x
//   exp_run         exp_recip carries a valid term this cycle
//   exp_recip       unsigned Q1.15 1/n
//   exp_x           signed Q(X_W-16).15 argument
//   exp_busy        evaluation in progress
//   exp_valid       one-cycle pulse, exp_value updated
//   exp_value       unsigned Q1.15 result in [0, 1.0], held between valids
//   exp_error       one-cycle pulse, term stream was truncated
// Optional (macro EXP_ACCEPT_EN):
//   rand_in         unsigned Q1.15 uniform sample
//   exp_accept      (rand_in < exp_value) or sat_one, updated with exp_valid
module exp_taylor_unit
  import replica_pkg::*;
#(
  parameter int X_W   = 24,
  parameter int Y_W   = 24,
  parameter int X_MIN = -(8 << 15)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        exp_init,
  input  logic                        exp_run,
  input  logic        [EXP_VAL_W-1:0] exp_recip,
  input  logic signed [X_W-1:0]       exp_x,
  output logic                        exp_busy,
  output logic                        exp_valid,
  output logic        [EXP_VAL_W-1:0] exp_value,
  output logic                        exp_error
`ifdef EXP_ACCEPT_EN
  ,
  input  logic        [EXP_VAL_W-1:0] rand_in,
  output logic                        exp_accept
`endif
);
  localparam int CNT_W = 4;
  localparam logic signed [X_W-1:0] XMIN_V = X_W'(X_MIN);

  exp_state_t state_q, state_d;
  logic signed [X_W-1:0] x_q, x_d;
  logic signed [Y_W-1:0] y_q, y_d, y_step;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic sat_one_q, sat_one_d, sat_zero_q, sat_zero_d;
  logic busy_q, busy_d, valid_q, valid_d, error_q, error_d;
  logic [EXP_VAL_W-1:0] value_q, value_d, clamp_val, final_val;
`ifdef EXP_ACCEPT_EN
  logic accept_q, accept_d;
`endif

  exp_horner_step #(.X_W(X_W), .Y_W(Y_W)) u_step (
    .x_i    (x_q),
    .recip_i(exp_recip),
    .y_i    (y_q),
    .y_o    (y_step)
  );

  // Series overshoot or undershoot is folded into [0, 1.0]; the sat flags
  // from the input clamp win over the computed value.
  always_comb begin
    if (y_step[Y_W-1])                  clamp_val = '0;
    else if (y_step > Y_W'(EXP_ONE))    clamp_val = EXP_VAL_W'(EXP_ONE);
    else                                clamp_val = y_step[EXP_VAL_W-1:0];
    if (sat_one_q)                      final_val = EXP_VAL_W'(EXP_ONE);
    else if (sat_zero_q)                final_val = '0;
    else                                final_val = clamp_val;
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    cnt_d      = cnt_q;
    sat_one_d  = sat_one_q;
    sat_zero_d = sat_zero_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    error_d    = 1'b0;
    value_d    = value_q;
`ifdef EXP_ACCEPT_EN
    accept_d   = accept_q;
`endif
    if (exp_init) begin
      // Restart from any state; an in-flight evaluation is silently dropped.
      state_d    = E_STEP;
      y_d        = Y_W'(EXP_ONE);
      cnt_d      = '0;
      busy_d     = 1'b1;
      sat_one_d  = !exp_x[X_W-1] && (exp_x != '0);
      sat_zero_d = exp_x < XMIN_V;
      if (sat_one_d)       x_d = '0;
      else if (sat_zero_d) x_d = XMIN_V;
      else                 x_d = exp_x;
    end else if (state_q == E_STEP) begin
      if (exp_run) begin
        y_d   = y_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(EXP_TERMS - 1)) begin
          state_d = E_IDLE;
          busy_d  = 1'b0;
          valid_d = 1'b1;
          value_d = final_val;
`ifdef EXP_ACCEPT_EN
          accept_d = (rand_in < final_val) || sat_one_q;
`endif
        end
      end else if (cnt_q != '0) begin
        // A gap before the first term is legal; a gap after it is not.
        state_d = E_IDLE;
        busy_d  = 1'b0;
        error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= E_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      cnt_q      <= '0;
      sat_one_q  <= 1'b0;
      sat_zero_q <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      value_q    <= '0;
`ifdef EXP_ACCEPT_EN
      accept_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      cnt_q      <= cnt_d;
      sat_one_q  <= sat_one_d;
      sat_zero_q <= sat_zero_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
      value_q    <= value_d;
`ifdef EXP_ACCEPT_EN
      accept_q   <= accept_d;
`endif
    end
  end

  assign exp_busy  = busy_q;
  assign exp_valid = valid_q;
  assign exp_value = value_q;
  assign exp_error = error_q;
`ifdef EXP_ACCEPT_EN
  assign exp_accept = accept_q;
`endif
endmodule

// File: tb/tb_exp_taylor_unit.sv
// Directed bench for exp_taylor_unit. Expected results are the real exp(x)
// values in Q1.15 (hand-computed), with an 8 LSB allowance for truncation.
module tb_exp_taylor_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic exp_init = 1'b0;
  logic exp_run = 1'b0;
  logic [16:0] exp_recip = '0;
  logic signed [23:0] exp_x = '0;
  logic exp_busy, exp_valid, exp_error;
  logic [16:0] exp_value;
`ifdef EXP_ACCEPT_EN
  logic [16:0] rand_in = '0;
  logic exp_accept;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nvalid = 0;
  int nerr = 0;

  exp_taylor_unit dut (
    .clk      (clk),
    .reset    (reset),
    .exp_init (exp_init),
    .exp_run  (exp_run),
    .exp_recip(exp_recip),
    .exp_x    (exp_x),
    .exp_busy (exp_busy),
    .exp_valid(exp_valid),
    .exp_value(exp_value),
    .exp_error(exp_error)
`ifdef EXP_ACCEPT_EN
    ,
    .rand_in  (rand_in),
    .exp_accept(exp_accept)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (exp_valid) nvalid <= nvalid + 1;
    if (exp_error) nerr <= nerr + 1;
  end

  task automatic chk(input string tag, input int act, input int expv, input int tol = 0);
    checks++;
    if (act < expv - tol || act > expv + tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, act, expv, tol);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16:0] recip(input int n);
    return 17'((32768 + n / 2) / n);
  endfunction

  // Init, optional idle gap, 15 terms, then one more cycle with exp_run=trail.
  // Returns the cycle of the first exp_valid seen and the value shown then.
  task automatic do_eval(input int x, input int gap, input bit trail,
                         output int vcyc, output int val);
    exp_x = 24'(x); exp_init = 1'b1; exp_run = 1'b0;
    tick();
    exp_init = 1'b0;
    vcyc = -1; val = -1;
    repeat (gap) tick();
    for (int n = 15; n >= 1; n--) begin
      exp_run = 1'b1; exp_recip = recip(n);
      tick();
      if (exp_valid && vcyc < 0) begin vcyc = cyc; val = int'(exp_value); end
    end
    exp_run = trail; exp_recip = recip(1);
    tick();
    exp_run = 1'b0;
    chk("vpulse", int'(exp_valid), 0);
    chk("busy_done", int'(exp_busy), 0);
    chk("hold", int'(exp_value), val);
  endtask

  initial begin
    int t0, vc, v, nv0, ne0, prev;
    repeat (3) tick();
    chk("rst_busy", int'(exp_busy), 0);
    chk("rst_valid", int'(exp_valid), 0);
    chk("rst_value", int'(exp_value), 0);
    chk("rst_error", int'(exp_error), 0);
`ifdef EXP_ACCEPT_EN
    chk("rst_accept", int'(exp_accept), 0);
`endif
    reset = 1'b1;

    // Back-to-back evaluations at fixed cycles.
    nv0 = nvalid; ne0 = nerr;
    while (cyc < 40) tick();
    do_eval(-16384, 0, 1'b0, vc, v);
    chk("b2b0_cyc", vc, 56);
    chk("b2b0_val", v, 19875, 8);
    while (cyc < 60) tick();
    do_eval(-65536, 0, 1'b0, vc, v);
    chk("b2b1_cyc", vc, 76);
    chk("b2b1_val", v, 4435, 8);
    chk("b2b_nvalid", nvalid - nv0, 2);
    chk("b2b_nerr", nerr - ne0, 0);

    // x = 0, with exp_run left high in the trailing cycle.
    t0 = cyc;
    do_eval(0, 0, 1'b1, vc, v);
    chk("zero_cyc", vc, t0 + 16);
    chk("zero_val", v, 32768);

    t0 = cyc;
    do_eval(-32768, 0, 1'b0, vc, v);
    chk("m1_cyc", vc, t0 + 16);
    chk("m1_val", v, 12055, 8);

    t0 = cyc;
    do_eval(16384, 0, 1'b0, vc, v);
    chk("pos_cyc", vc, t0 + 16);
    chk("pos_val", v, 32768);

    t0 = cyc;
    do_eval(-(20 << 15), 0, 1'b0, vc, v);
    chk("low_cyc", vc, t0 + 16);
    chk("low_val", v, 0);

    // Legal gap between init and first term.
    t0 = cyc;
    do_eval(-32768, 2, 1'b0, vc, v);
    chk("gap_cyc", vc, t0 + 18);
    chk("gap_val", v, 12055, 8);

    // Truncation after 10 terms.
    prev = int'(exp_value);
    nv0 = nvalid; ne0 = nerr;
    exp_x = -24'sd65536; exp_init = 1'b1; tick(); exp_init = 1'b0;
    for (int n = 15; n >= 6; n--) begin
      exp_run = 1'b1; exp_recip = recip(n); tick();
    end
    exp_run = 1'b0; tick();
    chk("trunc_err", int'(exp_error), 1);
    chk("trunc_busy", int'(exp_busy), 0);
    chk("trunc_value", int'(exp_value), prev);
    tick();
    chk("trunc_err_pulse", int'(exp_error), 0);
    chk("trunc_nvalid", nvalid - nv0, 0);
    chk("trunc_nerr", nerr - ne0, 1);

    // Restart mid-evaluation; init wins over a same-cycle term.
    nv0 = nvalid; ne0 = nerr;
    exp_x = -24'sd65536; exp_init = 1'b1; tick(); exp_init = 1'b0;
    for (int n = 15; n >= 11; n--) begin
      exp_run = 1'b1; exp_recip = recip(n); tick();
    end
    t0 = cyc;
    exp_x = 24'sd0; exp_init = 1'b1; exp_run = 1'b1; exp_recip = recip(10);
    tick();
    exp_init = 1'b0;
    chk("rs_busy", int'(exp_busy), 1);
    vc = -1; v = -1;
    for (int n = 15; n >= 1; n--) begin
      exp_recip = recip(n); tick();
      if (exp_valid && vc < 0) begin vc = cyc; v = int'(exp_value); end
    end
    exp_run = 1'b0; tick();
    chk("rs_cyc", vc, t0 + 16);
    chk("rs_val", v, 32768);
    chk("rs_nvalid", nvalid - nv0, 1);
    chk("rs_nerr", nerr - ne0, 0);

    // Reset at step 7, terms keep coming afterwards.
    nv0 = nvalid; ne0 = nerr;
    exp_x = -24'sd32768; exp_init = 1'b1; tick(); exp_init = 1'b0;
    for (int n = 15; n >= 9; n--) begin
      exp_run = 1'b1; exp_recip = recip(n); tick();
    end
    reset = 1'b0; exp_recip = recip(8); tick();
    chk("mr_busy", int'(exp_busy), 0);
    chk("mr_value", int'(exp_value), 0);
    reset = 1'b1;
    for (int n = 8; n >= 1; n--) begin
      exp_recip = recip(n); tick();
    end
    exp_run = 1'b0; tick();
    chk("mr_busy_after", int'(exp_busy), 0);
    chk("mr_nvalid", nvalid - nv0, 0);
    chk("mr_nerr", nerr - ne0, 0);

`ifdef EXP_ACCEPT_EN
    rand_in = 17'd12000;
    do_eval(-32768, 0, 1'b0, vc, v);
    chk("acc_lo", int'(exp_accept), 1);
    rand_in = 17'd13000;
    do_eval(-32768, 0, 1'b0, vc, v);
    chk("acc_hi", int'(exp_accept), 0);
    tick();
    chk("acc_hold", int'(exp_accept), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/exp_taylor_unit.md
Name: exp_taylor_unit

Overview:
- Downstream consumer of the node controller's exp_init / exp_run / exp_recip stream.
- Evaluates y = exp(x) for x ≤ 0 with a 15-term Horner Taylor series, y ← 1 + (x·(1/n))·y for n = 15…1, using one recip word per cycle.
- The result, Q1.15 in [0, 1.0], goes to the metropolis and replica-exchange decision logic. The unit accepts two evaluations per optimisation cycle.

Parameters:
- X_W, 24, signed width of exp_x; Q(X_W-16).15 format.
- Y_W, 24, signed width of the internal accumulator; Q.15 format.
- X_MIN, -(8<<15), most negative x evaluated; anything below it returns 0.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low.
- exp_init  in  1  start pulse; exp_x is sampled in this cycle.
- exp_run  in  1  high while exp_recip carries a valid term.
- exp_recip  in  17  unsigned Q1.15 value of 1/n, in the order 1/15 … 1/1.
- exp_x  in  X_W  signed argument.
- exp_busy  out  1  evaluation in progress.
- exp_valid  out  1  one-cycle pulse; exp_value is valid.
- exp_value  out  17  unsigned Q1.15 result, held until the next valid.
- exp_error  out  1  one-cycle pulse; the recip sequence was truncated.

Behaviour:
- Reset (reset=0, sampled on the clock edge): state IDLE; all outputs 0; y=0; step_cnt=0.
- States:
  - IDLE → STEP on exp_init.
  - STEP → IDLE when step_cnt reaches 15, or on truncation.
  - exp_init in any state, including STEP, restarts: x_reg ← clamped exp_x; y ← EXP_ONE; step_cnt ← 0; busy ← 1. Any in-flight result is dropped with no valid and no error. exp_init takes priority over a step in the same cycle.
- Input clamp at init:
  - exp_x > 0 → force flag sat_one.
  - exp_x < X_MIN → force flag sat_zero.
  - Either flag skips no cycles; the step sequence still runs. At completion the flag overrides the computed result with EXP_ONE or 0 respectively.
- Step: occurs in STEP on each cycle with exp_run=1.
  - t = (x_reg · exp_recip) >>> 15, signed, truncated.
  - p = (t · y) >>> 15.
  - y ← EXP_ONE + p, saturated to the signed Y_W range.
  - step_cnt ← step_cnt + 1.
- Completion: on the edge of the 15th step:
  - exp_value ← clamp(y_next, 0, EXP_ONE), subject to the sat flags.
  - exp_valid ← 1 for one cycle.
  - busy ← 0; state → IDLE.
- Latency: init in cycle T, exp_run high in T+1…T+15, exp_valid high in T+16.
- Truncation: exp_run=0 in STEP with 0 < step_cnt < 15 → exp_error pulse the next cycle, busy ← 0, exp_value unchanged.
  - exp_run=0 with step_cnt=0 (the gap between init and the first term) is legal.
- exp_run=1 in IDLE, including the trailing cycle after the 15th term, is ignored.
- Reset mid-evaluation: immediate abort; no valid, no error.

Optional Feature:
- Macro: EXP_ACCEPT_EN.
- Defined:
  - Adds input rand_in (17 bit, Q1.15) and output exp_accept.
  - In the exp_valid cycle, exp_accept ← (rand_in < exp_value) or sat_one.
  - exp_accept resets to 0 and holds between valids.
- Undefined: neither port exists, and no compare logic is built.

Decomposition:
- replica_pkg gains:
  - EXP_FRAC=15.
  - EXP_ONE=1<<15.
  - EXP_TERMS=15.
  - typedef enum logic {E_IDLE, E_STEP} exp_state_t.
- One sub-module, exp_horner_step: combinational t/p/saturate datapath (x_reg, recip, y → y_next). It is instantiated once, so the multiplier pair can later be pipelined in isolation.

Test Plan:
- x=0, standard 15-term sequence → exp_valid at T+16, exp_value=32768.
- x=-32768 (-1.0) → exp_value=12055 ±8 LSB.
- x=+16384 → exp_value=32768. x=-(20<<15) → exp_value=0. Both run the full 15-cycle timing.
- Init at cycles 40 and 60, x = -16384 then -65536 → two valid pulses at 56 and 76, values 19875 ±8 and 4435 ±8.
- exp_run dropped after 10 terms → exp_error at the next cycle, no exp_valid, exp_value keeps its previous value. Separately, reset=0 at step 7 → busy=0, no pulses.
- EXP_ACCEPT_EN with x=-1.0: rand_in=12000 → exp_accept=1; rand_in=13000 → exp_accept=0.
